alu_sequencer: RTL and testbench

Parametrised multi-op successor to the single-op ADDI nibble sequencer. Accepts an opcode plus immediate, fetches the second operand over the shared bus with a ready handshake, executes one of several ALU ops at `WIDTH` bits, and optionally drives the result back onto the bus. It sits between the pad-level wrapper (opcode/immediate pins, bidirectional bus) and the external register file.

---
 rtl/alu_sequencer_pkg.sv | 36 +++
 rtl/alu_sequencer_if.sv | 20 ++
 rtl/alu_sequencer_exec.sv | 40 ++++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, bus request codes and FSM state type for alu_sequencer.
// Opcodes 6/7 are only accepted when ALU_SHIFT_EN is defined.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUBI = 4'd2;
    localparam logic [3:0] OP_ANDI = 4'd3;
    localparam logic [3:0] OP_ORI  = 4'd4;
    localparam logic [3:0] OP_XORI = 4'd5;
    localparam logic [3:0] OP_SHLI = 4'd6;
    localparam logic [3:0] OP_SHRI = 4'd7;

    localparam logic [3:0] BUS_IDLE  = 4'b0000;
    localparam logic [3:0] BUS_REQ   = 4'b0011;
    localparam logic [3:0] BUS_READ  = 4'b0001;
    localparam logic [3:0] BUS_WRITE = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        EXEC,
        WRITE
    } state_e;

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: op_valid = 1'b1;
`ifdef ALU_SHIFT_EN
            OP_SHLI, OP_SHRI: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Shared register-file bus between alu_sequencer (master) and the bus agent (slave).
interface alu_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [3:0]       bus_req;
    logic             bus_ready;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;

    modport master (
        output bus_req, bus_out, bus_oe,
        input  bus_ready, bus_in
    );

    modport slave (
        input  bus_req, bus_out, bus_oe,
        output bus_ready, bus_in
    );
endinterface

// File: rtl/alu_sequencer_exec.sv
// Combinational WIDTH-bit ALU producing a WIDTH+1 result (MSB = carry/borrow).
// Shifter (opcodes 6/7) is built only when ALU_SHIFT_EN is defined.
module alu_sequencer_exec
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   c
);
    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};

`ifdef ALU_SHIFT_EN
    localparam logic [WIDTH-1:0] SH_LIMIT = WIDTH'(WIDTH);
`endif

    always_comb begin
        c = '0;
        case (op)
            OP_ADDI: c = a_x + b_x;
            // Wraps through bit WIDTH, so c[WIDTH] is the borrow (a < b).
            OP_SUBI: c = a_x - b_x;
            OP_ANDI: c = a_x & b_x;
            OP_ORI:  c = a_x | b_x;
            OP_XORI: c = a_x ^ b_x;
`ifdef ALU_SHIFT_EN
            OP_SHLI: c = (b >= SH_LIMIT) ? '0 : {1'b0, a << b};
            OP_SHRI: c = (b >= SH_LIMIT) ? '0 : {1'b0, a >> b};
`endif
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Opcode+immediate ALU sequencer: fetches operand B over the bus, executes, writes back.
// Define ALU_SHIFT_EN to enable the SHLI/SHRI opcodes.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    alu_sequencer_if.master  bus,
    input  logic             oe_n,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH:0]   c_q, c_d, alu_c;
    logic [WIDTH-1:0] result_q, result_d, bus_out_q, bus_out_d;
    logic             carry_q, carry_d, zero_q, zero_d;
    logic             done_q, done_d, err_q, err_d, bus_oe_q, bus_oe_d;
    logic [3:0]       bus_req_q, bus_req_d;
    logic             timeout_hit;

    alu_sequencer_exec #(.WIDTH(WIDTH)) u_exec (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .c  (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bus_req_q <= BUS_IDLE;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            err_q     <= err_d;
            bus_req_q <= bus_req_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op_valid(opcode)) begin
                    state_d = REQ;
                    op_d    = opcode;
                    a_d     = imm;
                    cnt_d   = '0;
                end
            end
            REQ, LOAD: begin
                if (bus.bus_ready) begin
                    cnt_d = '0;
                    if (state_q == REQ) begin
                        state_d = LOAD;
                    end else begin
                        b_d     = bus.bus_in;
                        state_d = EXEC;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                c_d     = alu_c;
                state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered off the next state so bus_req tracks the state
    // register and the write-back code lines up with bus_oe/done.
    always_comb begin
        bus_req_d = BUS_IDLE;
        bus_out_d = '0;
        bus_oe_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        case (state_d)
            REQ:     bus_req_d = BUS_REQ;
            LOAD:    bus_req_d = BUS_READ;
            default: bus_req_d = BUS_IDLE;
        endcase
        if ((state_q == IDLE && start && !op_valid(opcode)) || timeout_hit) begin
            done_d = 1'b1;
            err_d  = 1'b1;
        end
        if (state_q == WRITE) begin
            result_d = c_q[WIDTH-1:0];
            carry_d  = c_q[WIDTH];
            zero_d   = (c_q[WIDTH-1:0] == '0);
            done_d   = 1'b1;
            if (!oe_n) begin
                bus_req_d = BUS_WRITE;
                bus_oe_d  = 1'b1;
                bus_out_d = c_q[WIDTH-1:0];
            end
        end
    end

    assign bus.bus_req = bus_req_q;
    assign bus.bus_out = bus_out_q;
    assign bus.bus_oe  = bus_oe_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops against an arithmetic model.
// Honours ALU_SHIFT_EN the same way as the design.
module tb_alu_sequencer;
    localparam int W   = 4;
    localparam int MOD = 1 << W;
    localparam int TO  = 15;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   opcode;
    logic [W-1:0] imm;
    logic         oe_n;
    logic [W-1:0] result;
    logic         carry, zero, busy, done, err;

    int checks   = 0;
    int failures = 0;
    int m_res    = 0;
    int m_carry  = 0;
    int m_zero   = 0;

    alu_sequencer_if #(.WIDTH(W)) bus_if ();

    alu_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opcode (opcode),
        .imm    (imm),
        .bus    (bus_if.master),
        .oe_n   (oe_n),
        .result (result),
        .carry  (carry),
        .zero   (zero),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid(input int op);
        if (op >= 1 && op <= 5) return 1'b1;
`ifdef ALU_SHIFT_EN
        if (op == 6 || op == 7) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void m_exec(input int op, input int a, input int b,
                                   output int r, output int c);
        r = 0;
        c = 0;
        case (op)
            1: begin r = (a + b) % MOD; c = (a + b >= MOD) ? 1 : 0; end
            2: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (b >= W) ? 0 : (a * (1 << b)) % MOD;
            7: r = (b >= W) ? 0 : a / (1 << b);
            default: r = 0;
        endcase
    endfunction

    task automatic run_op(input int op, input int a, input int b, input bit oen,
                          input int wreq, input int wload, input bit repulse);
        int  req_left, load_left, lat, exp_lat, er, ec, extra;
        bit  ok, timed_out;
        ok = m_valid(op);
        m_exec(op, a, b, er, ec);
        timed_out = 1'b0;
        if (!ok) exp_lat = 1;
        else if (wreq >= TO) begin exp_lat = 1 + TO; timed_out = 1'b1; end
        else if (wload >= TO) begin exp_lat = 2 + wreq + TO; timed_out = 1'b1; end
        else exp_lat = 5 + wreq + wload;

        @(negedge clk);
        start            = 1'b1;
        opcode           = op[3:0];
        imm              = a[W-1:0];
        oe_n             = oen;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_in    = W'($urandom);
        req_left  = wreq;
        load_left = wload;
        lat       = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start  = repulse && (cyc == 2);
            opcode = 4'($urandom);
            imm    = W'($urandom);
            check("oe_vs_req", {31'd0, bus_if.bus_oe &&
                  (bus_if.bus_req == 4'b0011 || bus_if.bus_req == 4'b0001)}, 0);
            if (done) begin
                lat = cyc;
                break;
            end
            if (bus_if.bus_req == 4'b0011) begin
                bus_if.bus_ready = (req_left == 0);
                if (req_left > 0) req_left--;
            end else if (bus_if.bus_req == 4'b0001) begin
                bus_if.bus_ready = (load_left == 0);
                if (load_left > 0) load_left--;
            end else begin
                bus_if.bus_ready = 1'($urandom);
            end
            bus_if.bus_in = (bus_if.bus_req == 4'b0001 && bus_if.bus_ready) ?
                            b[W-1:0] : W'($urandom);
        end

        check("latency", lat, exp_lat);
        check("err", {31'd0, err}, (ok && !timed_out) ? 0 : 1);
        check("busy_at_done", {31'd0, busy}, 0);
        if (ok && !timed_out) begin
            m_res   = er;
            m_carry = ec;
            m_zero  = (er == 0) ? 1 : 0;
            check("bus_oe", {31'd0, bus_if.bus_oe}, oen ? 0 : 1);
            check("bus_req_wb", {28'd0, bus_if.bus_req}, oen ? 0 : 2);
            if (!oen) check("bus_out", {28'd0, bus_if.bus_out}, er);
        end else begin
            check("bus_oe_abort", {31'd0, bus_if.bus_oe}, 0);
            check("bus_req_abort", {28'd0, bus_if.bus_req}, 0);
        end
        check("result", {28'd0, result}, m_res);
        check("carry", {31'd0, carry}, m_carry);
        check("zero", {31'd0, zero}, m_zero);

        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) begin
                check("done_fall", {31'd0, done}, 0);
                check("bus_oe_fall", {31'd0, bus_if.bus_oe}, 0);
            end
            if (done) extra++;
        end
        check("extra_done", extra, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, {28'd0, result}, 0);
        check({tag, "_carry"}, {31'd0, carry}, 0);
        check({tag, "_zero"}, {31'd0, zero}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_err"}, {31'd0, err}, 0);
        check({tag, "_bus_req"}, {28'd0, bus_if.bus_req}, 0);
        check({tag, "_bus_oe"}, {31'd0, bus_if.bus_oe}, 0);
        check({tag, "_bus_out"}, {28'd0, bus_if.bus_out}, 0);
    endtask

    initial begin
        int extra, op, a, b;
        rst              = 1'b1;
        start            = 1'b0;
        opcode           = '0;
        imm              = '0;
        oe_n             = 1'b1;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_in    = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_op(1, 9, 8, 1'b0, 0, 0, 1'b0);
        run_op(2, 3, 5, 1'b1, 0, 0, 1'b0);
        run_op(5, 10, 10, 1'b0, 0, 0, 1'b1);
        run_op(3, 12, 10, 1'b0, 2, 3, 1'b0);
        run_op(4, 5, 2, 1'b1, 100, 0, 1'b0);
        run_op(2, 7, 1, 1'b0, 1, 100, 1'b0);
        run_op(1, 15, 1, 1'b0, 14, 14, 1'b0);
        run_op(6, 3, 2, 1'b0, 0, 0, 1'b0);
        run_op(7, 12, 2, 1'b0, 0, 0, 1'b0);
        run_op(0, 4, 4, 1'b0, 0, 0, 1'b0);
        run_op(15, 4, 4, 1'b0, 0, 0, 1'b0);

        // Reset while the op sits in EXEC.
        @(negedge clk);
        start = 1'b1; opcode = 4'd1; imm = 4'd7; oe_n = 1'b0;
        bus_if.bus_ready = 1'b1; bus_if.bus_in = 4'd5;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_pre_rst", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        m_res = 0; m_carry = 0; m_zero = 0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("midrst_no_done", extra, 0);
        run_op(1, 1, 1, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            op = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 7));
            a  = int'($urandom_range(0, MOD - 1));
            b  = int'($urandom_range(0, MOD - 1));
            run_op(op, a, b, 1'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), m_valid(op) && ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
